// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit
//   Tracks the destinations of the instructions downstream of decode and
//   decides, for each decode-stage source operand, whether to read the
//   register file or forward from stage k. A load that is too young to
//   forward stalls decode. A taken branch flushes decode and fetch for
//   FLUSH_DEPTH cycles, and the flush overrides any stall.
//
//   Optional build macro HAZARD_PERF_EN adds saturating 16-bit stall and
//   flush cycle counters (stall_cnt, flush_cnt).
module pipe_hazard_unit #(
   parameter int NUM_FWD_STAGES = 2,
   parameter int LOAD_LAT       = 1,
   parameter int FLUSH_DEPTH    = 1,
   parameter int RADDR_W        = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               id_valid,
   input  logic [RADDR_W-1:0] id_rs1,
   input  logic [RADDR_W-1:0] id_rs2,
   input  logic               id_use_rs1,
   input  logic               id_use_rs2,
   input  logic [RADDR_W-1:0] id_rd,
   input  logic               id_reg_wr,
   input  logic               id_is_load,
   input  logic               br_taken,
   output logic [1:0]         fwd_a,
   output logic [1:0]         fwd_b,
   output logic               stall,
   output logic               flush
`ifdef HAZARD_PERF_EN
   ,
   output logic [15:0]        stall_cnt,
   output logic [15:0]        flush_cnt
`endif
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_DEPTH - 1);

   // Shadow pipe, index 1 is the instruction that just left decode.
   logic               sh_vld [1:NUM_FWD_STAGES];
   logic               sh_wr  [1:NUM_FWD_STAGES];
   logic               sh_ld  [1:NUM_FWD_STAGES];
   logic [RADDR_W-1:0] sh_rd  [1:NUM_FWD_STAGES];

   logic [0:0] state;
   logic [1:0] cnt;

   logic [1:0] sel_a;
   logic [1:0] sel_b;
   logic       haz_a;
   logic       haz_b;

   // Youngest-match search per operand; scanning oldest to youngest lets the
   // youngest match overwrite older ones. A match on a load still inside its
   // latency window becomes a hazard instead of a forward.
   always_comb begin
      sel_a = 2'd0;
      sel_b = 2'd0;
      haz_a = 1'b0;
      haz_b = 1'b0;
      for (int k = NUM_FWD_STAGES; k >= 1; k--) begin
         if (id_use_rs1 && sh_vld[k] && sh_wr[k] &&
             (sh_rd[k] != '0) && (sh_rd[k] == id_rs1)) begin
            sel_a = 2'(k);
            haz_a = sh_ld[k] && (k <= LOAD_LAT);
         end
         if (id_use_rs2 && sh_vld[k] && sh_wr[k] &&
             (sh_rd[k] != '0) && (sh_rd[k] == id_rs2)) begin
            sel_b = 2'(k);
            haz_b = sh_ld[k] && (k <= LOAD_LAT);
         end
      end
   end

   // Output decode: a flush wins over a stall, and reset forces everything
   // quiet even while br_taken is high.
   always_comb begin
      flush = reset && ((state == ST_FLUSH) || br_taken);
      stall = (haz_a || haz_b) && !flush;
      fwd_a = haz_a ? 2'd0 : sel_a;
      fwd_b = haz_b ? 2'd0 : sel_b;
   end

   // Shadow pipe control bits: shift every cycle, bubble on stall/flush/idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 1; k <= NUM_FWD_STAGES; k++) begin
            sh_vld[k] <= 1'b0;
            sh_wr[k]  <= 1'b0;
            sh_ld[k]  <= 1'b0;
         end
      end else begin
         sh_vld[1] <= id_valid && !stall && !flush;
         sh_wr[1]  <= id_reg_wr;
         sh_ld[1]  <= id_is_load;
         for (int k = 2; k <= NUM_FWD_STAGES; k++) begin
            sh_vld[k] <= sh_vld[k-1];
            sh_wr[k]  <= sh_wr[k-1];
            sh_ld[k]  <= sh_ld[k-1];
         end
      end
   end

   // Shadow pipe destination addresses; only meaningful when valid is set.
   always_ff @(posedge clk) begin
      sh_rd[1] <= id_rd;
      for (int k = 2; k <= NUM_FWD_STAGES; k++) begin
         sh_rd[k] <= sh_rd[k-1];
      end
   end

   // Flush window FSM: cnt holds the flush cycles still owed after this one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= 2'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (br_taken && (FLUSH_DEPTH > 1)) begin
                  state <= ST_FLUSH;
                  cnt   <= FLUSH_RELOAD;
               end
            end
            default: begin
               if (br_taken) begin
                  cnt <= FLUSH_RELOAD;
               end else if (cnt <= 2'd1) begin
                  state <= ST_IDLE;
                  cnt   <= 2'd0;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   logic [15:0] stall_cnt_q;
   logic [15:0] flush_cnt_q;

   // Saturating counts of stall and flush cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= 16'd0;
         flush_cnt_q <= 16'd0;
      end else begin
         if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
         if (flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule
